prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Parametrised instruction loader for the enhanced processor's program RAM.
- On a Start pulse, streams a fixed program image into RAM through a valid/ready write handshake, one word per accepted beat, from a programmable base address.
- Reports Busy/Done and a word count so the processor holds off execution until the load completes.
- Successor to the fixed 5-bit/8-bit free-running loader; adds back-pressure, restart/abort and a completion flag.

Parameters:
- ADDR_W, 5, RAM address width in bits.
- DATA_W, 8, instruction word width in bits.
- PROG_LEN, 7, number of words in the image; legal range 0..2**ADDR_W.
- BASE_ADDR, 0, first RAM address written.
- Elaboration error if BASE_ADDR+PROG_LEN > 2**ADDR_W. No address wrap is permitted.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin or restart a load.
- Abort  in  1  terminate the current load; returns to IDLE without setting Done.
- WrReady  in  1  RAM accepts the current beat.
- WrEn  out  1  beat valid; Address/D are meaningful.
- Address  out  ADDR_W  RAM write address.
- D  out  DATA_W  RAM write data.
- Busy  out  1  high in LOAD.
- Done  out  1  sticky; high in DONE.
- Count  out  ADDR_W+1  words accepted in the current or last load.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; WrEn=0, Address=0, D=0, Busy=0, Done=0, Count=0; internal index=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - Start=1 and PROG_LEN>0 -> next edge enters LOAD with WrEn=1, Address=BASE_ADDR, D=image[0], index=0, Count=0, Busy=1.
  - Start=1 and PROG_LEN=0 -> goes directly to DONE with Count=0.
- LOAD:
  - A beat transfers on an edge where WrEn=1 and WrReady=1.
  - On transfer with index<PROG_LEN-1: index+1, Address+1, D=image[index+1], Count+1.
  - On transfer with index=PROG_LEN-1: enter DONE; WrEn=0, Busy=0, Done=1, Count=PROG_LEN. Address/D hold the last beat.
  - WrReady=0: Address, D and WrEn hold stable; no advance. Stalls are unbounded.
  - Start during LOAD is ignored.
- DONE:
  - Outputs hold.
  - Start -> restarts exactly as from IDLE; Done clears on the same edge.
- Abort:
  - Priority over Start and over a transfer on the same edge.
  - In LOAD: -> IDLE, WrEn=0, Busy=0, Done=0. Count keeps the number of already-accepted beats.
  - In IDLE or DONE: -> IDLE, Done=0.
- Latency:
  - Start to first WrEn: 1 cycle.
  - With WrReady tied high, Done rises PROG_LEN cycles after the first WrEn.
- Image: the word for each index comes combinationally from the image sub-module. Indices >= PROG_LEN return 0 and are never issued.
- Reset asserted mid-load: immediate return to reset values; WrEn drops asynchronously.

Decomposition:
- Shared package: state encoding type (IDLE/LOAD/DONE); default image constants (PROG_LEN=7 words 0x80,0x3E,0x80,0x3F,0x1E,0x7F,0xFF).
- Sub-module prog_image_rom:
  - Parameters DATA_W, PROG_LEN, ADDR_W.
  - Combinational index -> word lookup.
  - Swapped per program without touching the loader FSM.

Test Plan:
1. Reset low, then release; WrReady=1; pulse Start -> 7 beats at Address 0..6 with D=80,3E,80,3F,1E,7F,FF on consecutive cycles; Done=1 and Count=7 the cycle after the last beat; Busy=0.
2. WrReady toggled 1,0,0,1,... during the load -> Address/D stable while WrReady=0; every word written exactly once, in order; Count=7 at Done.
3. BASE_ADDR=20, PROG_LEN=7, ADDR_W=5 -> addresses 20..26; BASE_ADDR=26 with PROG_LEN=7 -> elaboration fails.
4. Abort asserted after 3 accepted beats, with Start pulsed on the same cycle -> IDLE, WrEn=0, Done=0, Count=3; a following Start reloads from BASE_ADDR with D=80.
5. Reset driven low mid-load (during beat 4) -> WrEn, Busy and Done fall without waiting for a clock edge; after release the block is idle until Start.
6. PROG_LEN=0: Start -> Done=1 next cycle, WrEn never asserted, Count=0. Start in DONE with PROG_LEN=7 -> full reload and Done re-rises.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and the default program image for the program RAM loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_PROG_LEN = 7;

  function automatic logic [7:0] def_image(input int idx);
    case (idx)
      0:       return 8'h80;
      1:       return 8'h3E;
      2:       return 8'h80;
      3:       return 8'h3F;
      4:       return 8'h1E;
      5:       return 8'h7F;
      6:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader_image_rom.sv
// Combinational program image lookup; replace this module to load a different program.
module prog_image_rom
  import prog_loader_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 7,
  parameter int ADDR_W   = 5
) (
  input  logic [ADDR_W:0]   index,
  output logic [DATA_W-1:0] word
);

  localparam logic [ADDR_W+1:0] LEN = (ADDR_W + 2)'(PROG_LEN);

  always_comb begin
    word = '0;
    if ({1'b0, index} < LEN) word = DATA_W'(def_image(int'(index)));
  end

endmodule

// File: rtl/prog_loader.sv
// Streams the program image into RAM over a valid/ready write port from BASE_ADDR,
// with restart, abort, sticky Done and a count of accepted words.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int PROG_LEN  = DEF_PROG_LEN,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic              WrReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] D,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Count
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'((PROG_LEN == 0) ? 0 : PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  if (PROG_LEN < 0 || PROG_LEN > 2 ** ADDR_W) begin : g_len_check
    $error("prog_loader: PROG_LEN out of range");
  end
  if (BASE_ADDR < 0 || BASE_ADDR + PROG_LEN > 2 ** ADDR_W) begin : g_wrap_check
    $error("prog_loader: image would run past the top of the address space");
  end

  state_t             state;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   rom_idx;
  logic [DATA_W-1:0]  rom_word;

  // The ROM always looks one word ahead: image[0] when idle, image[index+1] while loading.
  assign rom_idx = (state == LOAD) ? index + 1'b1 : '0;

  prog_image_rom #(
    .DATA_W  (DATA_W),
    .PROG_LEN(PROG_LEN),
    .ADDR_W  (ADDR_W)
  ) u_rom (
    .index(rom_idx),
    .word (rom_word)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      WrEn    <= 1'b0;
      Address <= '0;
      D       <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Count   <= '0;
      index   <= '0;
    end else if (Abort) begin
      // Count deliberately keeps the number of beats already accepted.
      state <= IDLE;
      WrEn  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            Count <= '0;
            if (PROG_LEN > 0) begin
              state   <= LOAD;
              WrEn    <= 1'b1;
              Busy    <= 1'b1;
              Done    <= 1'b0;
              Address <= BASE;
              D       <= rom_word;
              index   <= '0;
            end else begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (WrReady) begin
            Count <= Count + 1'b1;
            if (index == LAST_IDX) begin
              state <= DONE;
              WrEn  <= 1'b0;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              index   <= index + 1'b1;
              Address <= Address + 1'b1;
              D       <= rom_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: three loader instances (base 0, base 20, empty image) share one stimulus stream.
module tb_prog_loader;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } beat_t;

  logic Clock = 1'b0;
  logic Reset, Start, Abort, WrReady;

  logic       a_WrEn, a_Busy, a_Done;
  logic [4:0] a_Address;
  logic [7:0] a_D;
  logic [5:0] a_Count;
  logic       b_WrEn, b_Busy, b_Done;
  logic [4:0] b_Address;
  logic [7:0] b_D;
  logic [5:0] b_Count;
  logic       c_WrEn, c_Busy, c_Done;
  logic [4:0] c_Address;
  logic [7:0] c_D;
  logic [5:0] c_Count;

  int errors = 0;
  int checks = 0;

  logic [7:0] img [7] = '{8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hFF};
  beat_t qa[$];
  beat_t qb[$];

  bit m_load = 0;
  bit m_done = 0;
  int m_count = 0;
  bit c_done_m = 0;

  always #5 Clock = ~Clock;

  prog_loader #(.ADDR_W(5), .DATA_W(8), .PROG_LEN(7), .BASE_ADDR(0)) dut_a (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .WrReady(WrReady),
    .WrEn(a_WrEn), .Address(a_Address), .D(a_D), .Busy(a_Busy), .Done(a_Done), .Count(a_Count));

  prog_loader #(.ADDR_W(5), .DATA_W(8), .PROG_LEN(7), .BASE_ADDR(20)) dut_b (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .WrReady(WrReady),
    .WrEn(b_WrEn), .Address(b_Address), .D(b_D), .Busy(b_Busy), .Done(b_Done), .Count(b_Count));

  prog_loader #(.ADDR_W(5), .DATA_W(8), .PROG_LEN(0), .BASE_ADDR(0)) dut_c (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .WrReady(WrReady),
    .WrEn(c_WrEn), .Address(c_Address), .D(c_D), .Busy(c_Busy), .Done(c_Done), .Count(c_Count));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: the presented beat must match the queue head; an accepted beat retires it.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && a_WrEn === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_beat: got addr %0h data %0h, expected no beat", a_Address, a_D);
      end else begin
        check("a_addr", a_Address, qa[0].addr);
        check("a_data", a_D, qa[0].data);
        if (WrReady && !Abort) qa.delete(0);
      end
    end
  end

  always @(negedge Clock) begin
    if (Reset === 1'b1 && b_WrEn === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_beat: got addr %0h data %0h, expected no beat", b_Address, b_D);
      end else begin
        check("b_addr", b_Address, qb[0].addr);
        check("b_data", b_D, qb[0].data);
        if (WrReady && !Abort) qb.delete(0);
      end
    end
  end

  task automatic status_checks();
    check("a_wren", a_WrEn, m_load);
    check("a_busy", a_Busy, m_load);
    check("a_done", a_Done, m_done);
    check("a_count", a_Count, m_count);
    check("b_wren", b_WrEn, m_load);
    check("b_done", b_Done, m_done);
    check("b_count", b_Count, m_count);
    check("c_wren", c_WrEn, 1'b0);
    check("c_done", c_Done, c_done_m);
    check("c_count", c_Count, 0);
  endtask

  // One clock: drive inputs, advance the reference model at the edge, then check status.
  task automatic cyc(input bit st, input bit ab, input bit rdy);
    Start = st; Abort = ab; WrReady = rdy;
    @(posedge Clock);
    if (ab) begin
      m_load = 0; m_done = 0; c_done_m = 0;
      qa.delete(); qb.delete();
    end else begin
      if (st) c_done_m = 1;
      if (m_load) begin
        if (rdy) begin
          m_count++;
          if (m_count == 7) begin m_load = 0; m_done = 1; end
        end
      end else if (st) begin
        m_load = 1; m_done = 0; m_count = 0;
        for (int i = 0; i < 7; i++) begin
          qa.push_back('{addr: 5'(i), data: img[i]});
          qb.push_back('{addr: 5'(20 + i), data: img[i]});
        end
      end
    end
    #1;
    status_checks();
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; WrReady = 1'b1;
    #3;
    check("rst_wren", a_WrEn, 0);
    check("rst_addr", a_Address, 0);
    check("rst_d", a_D, 0);
    check("rst_done", a_Done, 0);
    check("rst_count", a_Count, 0);
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;

    // Straight load with WrReady high, then restart from DONE.
    cyc(1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);

    // Back-pressure pattern 1,0,0 repeating.
    cyc(1, 0, 1);
    for (int i = 0; i < 24; i++) cyc(0, 0, (i % 3) == 0);

    // Abort after three accepted beats with Start on the same edge, then reload.
    cyc(1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    cyc(1, 1, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);

    // Asynchronous reset while beat 4 is on the bus.
    cyc(1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    #2; Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    #1;
    check("arst_wren", a_WrEn, 0);
    check("arst_busy", a_Busy, 0);
    check("arst_done", a_Done, 0);
    check("arst_b_wren", b_WrEn, 0);
    m_load = 0; m_done = 0; m_count = 0; c_done_m = 0;
    qa.delete(); qb.delete();
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    check("a_all_written", qa.size(), 0);
    check("b_all_written", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
